// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave port between the inst and data masters. Grants are
// locked until accepted, and an in-order owner FIFO steers each data_ok back to its master.
module sram_like_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [31:0]      mem_rdata,
  output logic [PTR_W:0]   outstanding,
  output logic             proto_err
);

  // Handshake: a request is transferred in any cycle where req and addr_ok are both
  // high; a response is transferred in the single cycle its data_ok is high.
  typedef enum logic [1:0] {LOCK_NONE, LOCK_INST, LOCK_DATA} lock_t;

  lock_t            lock;
  lock_t            grant;
  logic [2:0]       starve_cnt;
  logic [DEPTH-1:0] owner_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             gnt_data;
  logic             accept;
  logic             pop;

  // Held in reset, nothing is granted so no request leaks to the slave.
  always_comb begin
    grant = LOCK_NONE;
    if (resetn) begin
      case (lock)
        LOCK_NONE: begin
          if (inst_req && (starve_cnt == 3'd4 || !data_req)) grant = LOCK_INST;
          else if (data_req)                                  grant = LOCK_DATA;
        end
        LOCK_INST: if (inst_req) grant = LOCK_INST;
        LOCK_DATA: if (data_req) grant = LOCK_DATA;
        default:   grant = LOCK_NONE;
      endcase
    end
  end

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign gnt_data = (grant == LOCK_DATA);

  assign mem_req   = (grant != LOCK_NONE) && !full;
  assign mem_wr    = gnt_data ? data_wr    : inst_wr;
  assign mem_size  = gnt_data ? data_size  : inst_size;
  assign mem_wstrb = gnt_data ? data_wstrb : inst_wstrb;
  assign mem_addr  = gnt_data ? data_addr  : inst_addr;
  assign mem_wdata = gnt_data ? data_wdata : inst_wdata;

  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && (grant == LOCK_INST);
  assign data_addr_ok = accept && gnt_data;

  assign pop          = mem_data_ok && !empty;
  assign inst_data_ok = pop && !owner_q[rd_ptr];
  assign data_data_ok = pop &&  owner_q[rd_ptr];
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign outstanding  = count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock       <= LOCK_NONE;
      starve_cnt <= '0;
      owner_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (grant == LOCK_NONE || accept) lock <= LOCK_NONE;
      else                              lock <= grant;

      // Counts back-to-back data transfers that made a waiting inst master wait.
      if (grant == LOCK_INST)      starve_cnt <= '0;
      else if (accept && gnt_data) starve_cnt <= !inst_req ? 3'd0 :
                                                 (starve_cnt == 3'd4) ? 3'd4 : starve_cnt + 3'd1;

      if (accept) begin
        owner_q[wr_ptr] <= gnt_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;

      if (mem_data_ok && empty) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a scripted slave returns responses in
// acceptance order while a scoreboard predicts which master each data_ok belongs to.
module tb_sram_like_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  outstanding;
  logic        proto_err;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  logic [31:0] slv_q[$];

  sram_like_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  task automatic drive_resp();
    mem_data_ok = 1'b1;
    mem_rdata   = (slv_q.size() != 0) ? slv_q.pop_front() : 32'hDEAD_BEEF;
  endtask

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_issue(input logic owner, input logic [31:0] addr, input logic [31:0] rd);
    chk("mem_req", {31'h0, mem_req}, 32'h1);
    chk("mem_addr", mem_addr, addr);
    chk("mem_wdata", mem_wdata, owner ? data_wdata : inst_wdata);
    chk("inst_addr_ok", {31'h0, inst_addr_ok}, {31'h0, !owner});
    chk("data_addr_ok", {31'h0, data_addr_ok}, {31'h0, owner});
    exp_q.push_back({owner, rd});
    slv_q.push_back(rd);
  endtask

  task automatic check_resp();
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL exp_q_underflow observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk("inst_data_ok", {31'h0, inst_data_ok}, {31'h0, !e[32]});
      chk("data_data_ok", {31'h0, data_data_ok}, {31'h0, e[32]});
      chk("inst_rdata", inst_rdata, e[31:0]);
      chk("data_rdata", data_rdata, e[31:0]);
    end
  endtask

  initial begin
    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_wdata = 32'hA0A0_0001;
    data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF; data_wdata = 32'hD0D0_0002;
    inst_addr = 32'h0; data_addr = 32'h0;

    // Reset: even with everything asserted, no handshake escapes
    resetn = 1'b0;
    idle();
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #3;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_inst_addr_ok", {31'h0, inst_addr_ok}, 32'h0);
    chk("rst_data_addr_ok", {31'h0, data_addr_ok}, 32'h0);
    chk("rst_inst_data_ok", {31'h0, inst_data_ok}, 32'h0);
    chk("rst_data_data_ok", {31'h0, data_data_ok}, 32'h0);
    chk("rst_outstanding", {29'h0, outstanding}, 32'h0);
    chk("rst_proto_err", {31'h0, proto_err}, 32'h0);
    repeat (2) cyc();
    idle();
    resetn = 1'b1;
    cyc();

    // Single inst fetch: addr_ok at once, response two cycles later
    idle(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1'b1; #1;
    check_issue(1'b0, 32'hBFC0_0000, 32'h3C08_0001);
    cyc();
    idle(); #1;
    chk("t1_outstanding", {29'h0, outstanding}, 32'h1);
    chk("t1_no_data_ok", {31'h0, inst_data_ok | data_data_ok}, 32'h0);
    cyc();
    idle(); drive_resp(); #1;
    check_resp();
    cyc();
    idle(); #1;
    chk("t1_drained", {29'h0, outstanding}, 32'h0);

    // Both request together: data wins, then inst; responses routed in order
    idle(); inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_addr = 32'h0000_1000; mem_addr_ok = 1'b1; #1;
    check_issue(1'b1, 32'h0000_1000, 32'h1111_0000);
    cyc();
    idle(); inst_req = 1'b1; mem_addr_ok = 1'b1; #1;
    check_issue(1'b0, 32'hBFC0_0004, 32'h2222_0000);
    cyc();
    idle(); drive_resp(); #1; check_resp(); cyc();
    idle(); drive_resp(); #1; check_resp(); cyc();

    // Slave stalls an inst grant; data arriving later cannot steal the port
    idle(); inst_req = 1'b1; inst_addr = 32'hBFC0_0008; data_addr = 32'h0000_1004; #1;
    chk("t3_stall_req", {31'h0, mem_req}, 32'h1);
    chk("t3_stall_addr0", mem_addr, 32'hBFC0_0008);
    cyc();
    for (int i = 1; i < 3; i++) begin
      idle(); inst_req = 1'b1; data_req = 1'b1; #1;
      chk("t3_stall_addr", mem_addr, 32'hBFC0_0008);
      chk("t3_stall_dok", {31'h0, data_addr_ok | inst_addr_ok}, 32'h0);
      cyc();
    end
    idle(); inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; #1;
    check_issue(1'b0, 32'hBFC0_0008, 32'h3333_0000);
    cyc();
    idle(); data_req = 1'b1; mem_addr_ok = 1'b1; #1;
    check_issue(1'b1, 32'h0000_1004, 32'h3333_0001);
    cyc();
    idle(); drive_resp(); #1; check_resp(); cyc();
    idle(); drive_resp(); #1; check_resp(); cyc();

    // Locked master withdraws: no issue that cycle, then the other master goes
    idle(); inst_req = 1'b1; inst_addr = 32'hBFC0_000C; #1;
    chk("flush_lock_addr", mem_addr, 32'hBFC0_000C);
    cyc();
    idle(); data_req = 1'b1; data_addr = 32'h0000_1008; mem_addr_ok = 1'b1; #1;
    chk("flush_no_req", {31'h0, mem_req}, 32'h0);
    chk("flush_no_addr_ok", {31'h0, data_addr_ok | inst_addr_ok}, 32'h0);
    cyc();
    idle(); data_req = 1'b1; mem_addr_ok = 1'b1; #1;
    chk("flush_outstanding", {29'h0, outstanding}, 32'h0);
    check_issue(1'b1, 32'h0000_1008, 32'h5555_0000);
    cyc();
    idle(); drive_resp(); #1; check_resp(); cyc();

    // Fill the FIFO, confirm full blocks issue even while popping
    for (int i = 0; i < 4; i++) begin
      idle(); data_req = 1'b1; data_addr = 32'h0000_3000 + 32'(i * 4); mem_addr_ok = 1'b1; #1;
      check_issue(1'b1, data_addr, 32'h4000_0000 + 32'(i));
      cyc();
    end
    idle(); data_req = 1'b1; data_addr = 32'h0000_3010; mem_addr_ok = 1'b1; #1;
    chk("full_outstanding", {29'h0, outstanding}, 32'h4);
    chk("full_no_req", {31'h0, mem_req}, 32'h0);
    chk("full_no_addr_ok", {31'h0, data_addr_ok}, 32'h0);
    cyc();
    idle(); data_req = 1'b1; mem_addr_ok = 1'b1; drive_resp(); #1;
    chk("full_pop_no_req", {31'h0, mem_req}, 32'h0);
    check_resp();
    cyc();
    idle(); data_req = 1'b1; mem_addr_ok = 1'b1; #1;
    chk("resume_outstanding", {29'h0, outstanding}, 32'h3);
    check_issue(1'b1, 32'h0000_3010, 32'h4000_0004);
    cyc();
    for (int i = 0; i < 4; i++) begin
      idle(); drive_resp(); #1; check_resp(); cyc();
    end
    idle(); #1;
    chk("full_drained", {29'h0, outstanding}, 32'h0);

    // Starvation guard: inst gets the fifth slot despite continuous data_req
    inst_addr = 32'hBFC0_0100;
    for (int i = 0; i < 6; i++) begin
      idle();
      data_req = 1'b1; data_addr = 32'h0000_2000 + 32'(i * 4);
      inst_req = (i <= 4); mem_addr_ok = 1'b1;
      if (i > 0) drive_resp();
      #1;
      if (i > 0) check_resp();
      if (i == 4) check_issue(1'b0, 32'hBFC0_0100, 32'h6600_0000 + 32'(i));
      else        check_issue(1'b1, data_addr, 32'h6600_0000 + 32'(i));
      cyc();
    end
    idle(); drive_resp(); #1; check_resp(); cyc();
    idle(); #1;
    chk("starve_drained", {29'h0, outstanding}, 32'h0);

    // Reset mid-transaction, then the late response is a protocol error
    idle(); inst_req = 1'b1; inst_addr = 32'hBFC0_0200; mem_addr_ok = 1'b1; #1;
    chk("late_issue", {31'h0, inst_addr_ok}, 32'h1);
    cyc();
    idle(); resetn = 1'b0; #1;
    chk("late_rst_outstanding", {29'h0, outstanding}, 32'h0);
    cyc();
    resetn = 1'b1;
    cyc();
    idle(); mem_data_ok = 1'b1; mem_rdata = 32'h7777_0000; #1;
    chk("orphan_inst_data_ok", {31'h0, inst_data_ok}, 32'h0);
    chk("orphan_data_data_ok", {31'h0, data_data_ok}, 32'h0);
    chk("orphan_err_before", {31'h0, proto_err}, 32'h0);
    cyc();
    idle(); #1;
    chk("proto_err_set", {31'h0, proto_err}, 32'h1);
    repeat (3) cyc();
    chk("proto_err_sticky", {31'h0, proto_err}, 32'h1);
    resetn = 1'b0; #1;
    chk("proto_err_cleared", {31'h0, proto_err}, 32'h0);
    cyc();
    resetn = 1'b1;
    cyc();

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL exp_q_leftover observed=%0d expected=0", exp_q.size());
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
